// File: rtl/gbd_sram_pkg.sv
// rtl/gbd_sram_pkg.sv - shared state, owner encoding and default timing for the SRAM arbiter
`timescale 1ns/1ps
package gbd_sram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CART = 2'b01;
    localparam logic [1:0] OWN_CAM  = 2'b10;

    localparam int DEF_ADDR_W  = 17;
    localparam int DEF_T_SETUP = 2;
    localparam int DEF_T_PULSE = 6;
    localparam int DEF_T_HOLD  = 2;

    // Phase counters count T-1 down to 0, so a phase lasts exactly T cycles.
    function automatic logic [3:0] phase_load(input int t);
        return 4'(t - 1);
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - 4-bit load/decrement phase counter with done flag
`timescale 1ns/1ps
module sram_phase_timer (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    output logic [3:0] o_count,
    output logic       o_done
);

    logic [3:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_count = r_count;
    assign o_done  = (r_count == 4'd0);

endmodule

// File: rtl/gbd_sram_arbiter.sv
// rtl/gbd_sram_arbiter.sv - cart/camera SRAM arbiter with generated strobes; SRAM_ARB_ROUND_ROBIN_EN selects round-robin ties
`timescale 1ns/1ps
module gbd_sram_arbiter
    import gbd_sram_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_PULSE = DEF_T_PULSE,
    parameter int T_HOLD  = DEF_T_HOLD
) (
    input  logic              sys_clock,
    input  logic              sys_resetn,
    input  logic              cart_req,
    input  logic              cart_wr,
    input  logic [ADDR_W-1:0] cart_addr,
    input  logic [7:0]        cart_wdata,
    output logic [7:0]        cart_rdata,
    output logic              cart_ack,
    input  logic              cam_req,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [7:0]        cam_wdata,
    output logic              cam_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_in,
    output logic              sram_ncs,
    output logic              sram_nwe,
    output logic              sram_noe,
    output logic              busy,
    output logic [1:0]        owner
);

    if (T_SETUP < 1 || T_SETUP > 16 || T_PULSE < 1 || T_PULSE > 16 ||
        T_HOLD < 1 || T_HOLD > 16) begin : g_bad_timing
        $error("gbd_sram_arbiter: T_SETUP/T_PULSE/T_HOLD must be 1..16");
    end

    localparam logic [3:0] LD_SETUP = phase_load(T_SETUP);
    localparam logic [3:0] LD_PULSE = phase_load(T_PULSE);
    localparam logic [3:0] LD_HOLD  = phase_load(T_HOLD);

    arb_state_t r_state;
    logic       r_wr;
    logic       w_grant_cart;
    logic       w_grant_cam;
    logic       w_load;
    logic [3:0] w_load_val;
    logic [3:0] w_count;
    logic       w_done;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic r_last_cam;
    assign w_grant_cart = cart_req && (!cam_req || r_last_cam);
`else
    assign w_grant_cart = cart_req;
`endif
    assign w_grant_cam = cam_req && !w_grant_cart;

    always_comb begin
        w_load     = 1'b0;
        w_load_val = 4'd0;
        case (r_state)
            IDLE:    begin w_load = cart_req || cam_req; w_load_val = LD_SETUP; end
            SETUP:   begin w_load = w_done;              w_load_val = LD_PULSE; end
            PULSE:   begin w_load = w_done;              w_load_val = LD_HOLD;  end
            default: begin w_load = 1'b0;                w_load_val = 4'd0;     end
        endcase
    end

    sram_phase_timer u_timer (
        .i_clk      (sys_clock),
        .i_rst_n    (sys_resetn),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_count    (w_count),
        .o_done     (w_done)
    );

    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_state     <= IDLE;
            r_wr        <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= 8'h00;
            sram_dq_oe  <= 1'b0;
            sram_ncs    <= 1'b1;
            sram_nwe    <= 1'b1;
            sram_noe    <= 1'b1;
            cart_rdata  <= 8'h00;
            cart_ack    <= 1'b0;
            cam_ack     <= 1'b0;
            busy        <= 1'b0;
            owner       <= OWN_NONE;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            r_last_cam  <= 1'b1;
`endif
        end else begin
            cart_ack <= 1'b0;
            cam_ack  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Address, data and direction are latched here so requesters may change freely afterwards.
                    if (w_grant_cart || w_grant_cam) begin
                        r_state     <= SETUP;
                        r_wr        <= w_grant_cart ? cart_wr : 1'b1;
                        sram_addr   <= w_grant_cart ? cart_addr : cam_addr;
                        sram_dq_out <= w_grant_cart ? cart_wdata : cam_wdata;
                        sram_dq_oe  <= w_grant_cart ? cart_wr : 1'b1;
                        sram_ncs    <= 1'b0;
                        busy        <= 1'b1;
                        owner       <= w_grant_cart ? OWN_CART : OWN_CAM;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                        r_last_cam  <= w_grant_cam;
`endif
                    end
                end
                SETUP: begin
                    if (w_done) begin
                        r_state  <= PULSE;
                        sram_nwe <= !r_wr;
                        sram_noe <= r_wr;
                    end
                end
                PULSE: begin
                    if (w_done) begin
                        r_state  <= HOLD;
                        sram_nwe <= 1'b1;
                        sram_noe <= 1'b1;
                        if (!r_wr) cart_rdata <= sram_dq_in;
                        if (T_HOLD == 1) begin
                            cart_ack <= (owner == OWN_CART);
                            cam_ack  <= (owner == OWN_CAM);
                        end
                    end
                end
                default: begin
                    // Ack is registered, so it is raised on entry to the last HOLD cycle.
                    if (w_count == 4'd1) begin
                        cart_ack <= (owner == OWN_CART);
                        cam_ack  <= (owner == OWN_CAM);
                    end
                    if (w_done) begin
                        r_state    <= IDLE;
                        sram_ncs   <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        busy       <= 1'b0;
                        owner      <= OWN_NONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gbd_sram_arbiter.sv
// tb/tb_gbd_sram_arbiter.sv - directed self-checking bench for gbd_sram_arbiter
`timescale 1ns/1ps
module tb_gbd_sram_arbiter;
    import gbd_sram_pkg::*;

    localparam int NH = 32;

    logic        sys_clock = 1'b0;
    logic        sys_resetn;
    logic        cart_req, cart_wr, cam_req;
    logic [16:0] cart_addr, cam_addr;
    logic [7:0]  cart_wdata, cam_wdata;
    logic [7:0]  cart_rdata;
    logic        cart_ack, cam_ack;
    logic [16:0] sram_addr;
    logic [7:0]  sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ncs, sram_nwe, sram_noe;
    logic        busy;
    logic [1:0]  owner;
    logic [7:0]  model_rd;

    int errors = 0;
    int checks = 0;

    logic        h_ncs [NH];
    logic        h_nwe [NH];
    logic        h_noe [NH];
    logic        h_oe  [NH];
    logic [16:0] h_addr[NH];
    logic [7:0]  h_dout[NH];
    logic [7:0]  h_rd  [NH];
    logic [1:0]  h_own [NH];
    int          cart_j, cam_j, cart_n, cam_n;
    bit          drop_all;

    always #5 sys_clock = ~sys_clock;

    assign sram_dq_in = (!sram_ncs && !sram_noe) ? model_rd : 8'h00;

    gbd_sram_arbiter dut (
        .sys_clock  (sys_clock),
        .sys_resetn (sys_resetn),
        .cart_req   (cart_req),
        .cart_wr    (cart_wr),
        .cart_addr  (cart_addr),
        .cart_wdata (cart_wdata),
        .cart_rdata (cart_rdata),
        .cart_ack   (cart_ack),
        .cam_req    (cam_req),
        .cam_addr   (cam_addr),
        .cam_wdata  (cam_wdata),
        .cam_ack    (cam_ack),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_ncs   (sram_ncs),
        .sram_nwe   (sram_nwe),
        .sram_noe   (sram_noe),
        .busy       (busy),
        .owner      (owner)
    );

    // Sample j is taken at the negedge after the j-th posedge following request launch.
    task automatic watch(input int n, input int inj_j, input int inj_kind);
        cart_j = 0; cam_j = 0; cart_n = 0; cam_n = 0;
        for (int j = 1; j <= n; j++) begin
            @(negedge sys_clock);
            h_ncs[j] = sram_ncs; h_nwe[j] = sram_nwe; h_noe[j] = sram_noe; h_oe[j] = sram_dq_oe;
            h_addr[j] = sram_addr; h_dout[j] = sram_dq_out; h_rd[j] = cart_rdata; h_own[j] = owner;
            if (cart_ack) begin
                cart_n++; if (cart_j == 0) cart_j = j;
                cart_req = 1'b0; if (drop_all) cam_req = 1'b0;
            end
            if (cam_ack) begin
                cam_n++; if (cam_j == 0) cam_j = j;
                cam_req = 1'b0; if (drop_all) cart_req = 1'b0;
            end
            if (j == inj_j && inj_kind == 1) begin
                cart_req = 1'b1; cart_wr = 1'b1; cart_addr = 17'h00042; cart_wdata = 8'h5A;
            end else if (j == inj_j && inj_kind == 2) begin
                cart_req = 1'b0; cart_addr = 17'h1FFFF; cart_wdata = 8'h00;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clock);
        sys_resetn = 1'b0;
        cart_req = 1'b0; cam_req = 1'b0;
        @(negedge sys_clock);
        sys_resetn = 1'b1;
        @(negedge sys_clock);
    endtask

    task automatic test_reset();
        sys_resetn = 1'b0;
        cart_req = 1'b0; cart_wr = 1'b0; cart_addr = '0; cart_wdata = 8'h00;
        cam_req = 1'b0; cam_addr = '0; cam_wdata = 8'h00; model_rd = 8'h00; drop_all = 1'b0;
        repeat (2) @(negedge sys_clock);
        sys_resetn = 1'b1;
        @(negedge sys_clock);
        checks++; if ({sram_ncs, sram_nwe, sram_noe, sram_dq_oe} !== 4'b1110) begin errors++;
            $display("FAIL reset_strobes: got %b expected 1110", {sram_ncs, sram_nwe, sram_noe, sram_dq_oe}); end
        checks++; if ({sram_addr, sram_dq_out, cart_rdata} !== 33'h0) begin errors++;
            $display("FAIL reset_data: got addr=%h dout=%h rdata=%h expected all 0", sram_addr, sram_dq_out, cart_rdata); end
        checks++; if ({cart_ack, cam_ack, busy, owner} !== 5'b00000) begin errors++;
            $display("FAIL reset_status: got %b expected 00000", {cart_ack, cam_ack, busy, owner}); end
    endtask

    task automatic test_cam_write();
        int nwe_cnt, noe_cnt, bad, first_we;
        cam_addr = 17'h00123; cam_wdata = 8'hA5; cam_req = 1'b1;
        watch(14, 0, 0);
        nwe_cnt = 0; noe_cnt = 0; bad = 0; first_we = 0;
        for (int j = 1; j <= 14; j++) begin
            if (!h_nwe[j]) begin nwe_cnt++; if (first_we == 0) first_we = j; end
            if (!h_noe[j]) noe_cnt++;
            if (j <= 10 && (h_addr[j] !== 17'h00123 || h_dout[j] !== 8'hA5 || h_oe[j] !== 1'b1 || h_ncs[j] !== 1'b0)) bad++;
        end
        checks++; if (cam_j !== 10) begin errors++; $display("FAIL cam_write_ack_cycle: got %0d expected 10", cam_j); end
        checks++; if (cam_n !== 1 || cart_n !== 0) begin errors++;
            $display("FAIL cam_write_ack_count: got cam=%0d cart=%0d expected 1/0", cam_n, cart_n); end
        checks++; if (nwe_cnt !== 6 || first_we !== 3) begin errors++;
            $display("FAIL cam_write_nwe: got %0d cycles from %0d expected 6 from 3", nwe_cnt, first_we); end
        checks++; if (noe_cnt !== 0) begin errors++; $display("FAIL cam_write_noe: got %0d expected 0", noe_cnt); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL cam_write_stable: got %0d unstable cycles expected 0", bad); end
        checks++; if (h_own[1] !== OWN_CAM) begin errors++; $display("FAIL cam_write_owner: got %b expected 10", h_own[1]); end
        checks++; if (h_ncs[11] !== 1'b1 || h_oe[11] !== 1'b0 || h_own[11] !== OWN_NONE) begin errors++;
            $display("FAIL cam_write_release: got ncs=%b oe=%b owner=%b expected 1/0/00", h_ncs[11], h_oe[11], h_own[11]); end
    endtask

    task automatic test_cart_read();
        int nwe_cnt, noe_cnt, oe_cnt, bad;
        model_rd = 8'h3C; cart_wr = 1'b0; cart_addr = 17'h1ABCD; cart_req = 1'b1;
        watch(14, 0, 0);
        model_rd = 8'h00;
        nwe_cnt = 0; noe_cnt = 0; oe_cnt = 0; bad = 0;
        for (int j = 1; j <= 14; j++) begin
            if (!h_nwe[j]) nwe_cnt++;
            if (!h_noe[j]) noe_cnt++;
            if (h_oe[j]) oe_cnt++;
            if (j <= 10 && h_addr[j] !== 17'h1ABCD) bad++;
        end
        checks++; if (cart_j !== 10) begin errors++; $display("FAIL cart_read_ack_cycle: got %0d expected 10", cart_j); end
        checks++; if (h_rd[10] !== 8'h3C) begin errors++; $display("FAIL cart_read_data: got %h expected 3c", h_rd[10]); end
        checks++; if (noe_cnt !== 6 || nwe_cnt !== 0) begin errors++;
            $display("FAIL cart_read_strobes: got noe=%0d nwe=%0d expected 6/0", noe_cnt, nwe_cnt); end
        checks++; if (oe_cnt !== 0) begin errors++; $display("FAIL cart_read_dq_oe: got %0d cycles expected 0", oe_cnt); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL cart_read_addr: got %0d bad cycles expected 0", bad); end
        checks++; if (h_rd[14] !== 8'h3C) begin errors++; $display("FAIL cart_read_hold: got %h expected 3c", h_rd[14]); end
    endtask

    task automatic test_cart_during_cam();
        int nwe_cnt, bad;
        cam_addr = 17'h00200; cam_wdata = 8'h11; cam_req = 1'b1;
        watch(24, 4, 1);
        nwe_cnt = 0; bad = 0;
        for (int j = 1; j <= 24; j++) begin
            if (!h_nwe[j]) nwe_cnt++;
            if (j >= 5 && j <= 10 && (h_addr[j] !== 17'h00200 || h_dout[j] !== 8'h11)) bad++;
        end
        checks++; if (cam_j !== 10 || bad !== 0) begin errors++;
            $display("FAIL no_preempt_cam: got ack=%0d bad=%0d expected 10/0", cam_j, bad); end
        checks++; if (h_ncs[11] !== 1'b1 || h_ncs[12] !== 1'b0 || h_own[12] !== OWN_CART || h_addr[12] !== 17'h00042) begin errors++;
            $display("FAIL no_preempt_cart_start: got ncs11=%b ncs12=%b own=%b addr=%h expected 1/0/01/00042",
                     h_ncs[11], h_ncs[12], h_own[12], h_addr[12]); end
        checks++; if (cart_j !== 21) begin errors++; $display("FAIL no_preempt_cart_ack: got %0d expected 21", cart_j); end
        checks++; if (nwe_cnt !== 12) begin errors++; $display("FAIL no_preempt_nwe: got %0d expected 12", nwe_cnt); end
    endtask

    task automatic test_drop_early();
        int bad, idle_cnt;
        cart_wr = 1'b1; cart_addr = 17'h0F0F0; cart_wdata = 8'h77; cart_req = 1'b1;
        watch(16, 1, 2);
        bad = 0; idle_cnt = 0;
        for (int j = 1; j <= 16; j++) begin
            if (j <= 10 && (h_addr[j] !== 17'h0F0F0 || h_dout[j] !== 8'h77)) bad++;
            if (j >= 11 && h_ncs[j] === 1'b1) idle_cnt++;
        end
        checks++; if (cart_j !== 10 || cart_n !== 1) begin errors++;
            $display("FAIL drop_ack: got cycle=%0d count=%0d expected 10/1", cart_j, cart_n); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL drop_latched: got %0d bad cycles expected 0", bad); end
        checks++; if (idle_cnt !== 6) begin errors++; $display("FAIL drop_no_repeat: got %0d idle cycles expected 6", idle_cnt); end
    endtask

    task automatic test_tie();
        logic [1:0] exp_c;
        do_reset();
        cart_wr = 1'b1; cart_addr = 17'h00010; cart_wdata = 8'h01;
        cam_addr = 17'h00020; cam_wdata = 8'h02;
        cart_req = 1'b1; cam_req = 1'b1;
        watch(24, 0, 0);
        checks++; if (h_own[1] !== OWN_CART || cart_j !== 10) begin errors++;
            $display("FAIL tie_a_cart: got owner=%b ack=%0d expected 01/10", h_own[1], cart_j); end
        checks++; if (cam_j !== 21 || h_own[12] !== OWN_CAM) begin errors++;
            $display("FAIL tie_a_cam: got ack=%0d owner=%b expected 21/10", cam_j, h_own[12]); end
        drop_all = 1'b1;
        cart_req = 1'b1; cam_req = 1'b1;
        watch(12, 0, 0);
        checks++; if (h_own[1] !== OWN_CART || cart_j !== 10 || cam_n !== 0) begin errors++;
            $display("FAIL tie_b: got owner=%b cart=%0d camn=%0d expected 01/10/0", h_own[1], cart_j, cam_n); end
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        exp_c = OWN_CAM;
`else
        exp_c = OWN_CART;
`endif
        cart_req = 1'b1; cam_req = 1'b1;
        watch(12, 0, 0);
        checks++; if (h_own[1] !== exp_c || (cart_j == 10) !== (exp_c == OWN_CART) || (cam_j == 10) !== (exp_c == OWN_CAM)) begin
            errors++; $display("FAIL tie_c: got owner=%b cart=%0d cam=%0d expected owner %b", h_own[1], cart_j, cam_j, exp_c); end
        drop_all = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acks;
        cam_addr = 17'h00300; cam_wdata = 8'hC3; cam_req = 1'b1;
        watch(5, 0, 0);
        checks++; if (h_nwe[5] !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse: got nwe=%b expected 0", h_nwe[5]); end
        sys_resetn = 1'b0; cam_req = 1'b0;
        #1;
        checks++; if ({sram_ncs, sram_nwe, sram_noe, sram_dq_oe, busy, owner} !== 7'b1110000) begin errors++;
            $display("FAIL rst_mid_outputs: got %b expected 1110000", {sram_ncs, sram_nwe, sram_noe, sram_dq_oe, busy, owner}); end
        acks = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge sys_clock);
            if (cam_ack || cart_ack) acks++;
        end
        sys_resetn = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge sys_clock);
            if (cam_ack || cart_ack) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL rst_mid_no_ack: got %0d acks expected 0", acks); end
        cam_addr = 17'h00301; cam_req = 1'b1;
        watch(12, 0, 0);
        checks++; if (cam_j !== 10 || h_addr[1] !== 17'h00301) begin errors++;
            $display("FAIL rst_mid_recover: got ack=%0d addr=%h expected 10/00301", cam_j, h_addr[1]); end
    endtask

    initial begin
        test_reset();
        test_cam_write();
        test_cart_read();
        test_cart_during_cam();
        test_drop_early();
        test_tie();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gbd_sram_arbiter.md
# gbd_sram_arbiter

Shares the cartridge SRAM between two requesters: the Game Boy cart-bus side (CPU reads and writes) and the camera image writer that fills bank0 after each capture. It runs a level-based request/acknowledge handshake on each side and arbitrates between pending requests. It generates every SRAM strobe itself, with parameterised setup, pulse and hold phase lengths, so requesters never drive nCS, nWE or nOE directly. It sits between the cart-bus glue and the camera write engine on one side and the SRAM pins on the other.

## Interface
- ADDR_W, 17, SRAM address width
- T_SETUP, 2, cycles with address and data stable before the strobe
- T_PULSE, 6, cycles with nWE or nOE low
- T_HOLD, 2, cycles after the strobe rises before release
- sys_clock  in  1  system clock
- sys_resetn  in  1  reset, asynchronous, active-low
- cart_req  in  1  cart access request, level
- cart_wr  in  1  1 = write, 0 = read
- cart_addr  in  ADDR_W  cart address
- cart_wdata  in  8  cart write data
- cart_rdata  out  8  read data, valid on the cart_ack cycle and held until the next cart read
- cart_ack  out  1  one-cycle completion pulse
- cam_req  in  1  camera write request, level, writes only
- cam_addr  in  ADDR_W  camera address
- cam_wdata  in  8  camera write data
- cam_ack  out  1  one-cycle completion pulse
- sram_addr  out  ADDR_W  SRAM address
- sram_dq_out  out  8  SRAM write data
- sram_dq_oe  out  1  data pin output enable
- sram_dq_in  in  8  SRAM read data
- sram_ncs  out  1  chip enable, active-low
- sram_nwe  out  1  write enable, active-low
- sram_noe  out  1  output enable, active-low
- busy  out  1  high in any state other than IDLE
- owner  out  2  00 none, 01 cart, 10 cam

## Operation
- States: IDLE → SETUP → PULSE → HOLD → IDLE.
- IDLE:
  - Samples the requests and grants one winner.
  - Latches the winner's address, write flag and data into internal registers.
  - Sets owner, then goes to SETUP.
- SETUP (T_SETUP cycles):
  - sram_ncs=0 and sram_addr driven from the latched address.
  - For a write, sram_dq_oe=1 and sram_dq_out holds the latched data.
- PULSE (T_PULSE cycles):
  - A write drives sram_nwe=0.
  - A read drives sram_noe=0 and captures sram_dq_in into the cart_rdata register on the last PULSE cycle.
- HOLD (T_HOLD cycles):
  - Strobes return high; address and data are held.
  - The owner's ack pulses on the final HOLD cycle.
  - Next state is IDLE, where ncs=1, dq_oe=0 and owner=00.
- Arbitration: the cart has fixed priority. When both requests are high in IDLE, the cart wins.
- No preemption: a cart request arriving mid-cycle waits for the current cycle to finish.
- The phase counter is 4 bits, loaded with T_x−1 on entry to each phase and decremented to 0. T_x values of 1–16 are legal; 0 is illegal and is checked by an elaboration assertion.
- The internal latch makes the cycle immune to requester changes. If req drops before ack, the cycle still completes and ack still pulses.
- A requester keeping req high after its ack is treated as a new request in the following IDLE cycle.

## Timing
- Reset values:
  - sram_ncs=1, sram_nwe=1, sram_noe=1, sram_dq_oe=0.
  - sram_addr=0, sram_dq_out=0, cart_rdata=0.
  - cart_ack=0, cam_ack=0, busy=0, owner=00.
  - State is IDLE.
- Latency: a request sampled in IDLE at edge k produces an ack in cycle k+T_SETUP+T_PULSE+T_HOLD. With defaults that is 10 cycles, and the state returns to IDLE at edge k+10.
- Back-to-back accesses: IDLE lasts at least 1 cycle, so the period per access is 1+T_SETUP+T_PULSE+T_HOLD, which is 11 with defaults.
- Worst-case cart wait is one full camera access plus its own access, 21 cycles with defaults.
- Reset asserted mid-access: all outputs return to reset values immediately, no ack is issued, and the in-flight access is lost.

## Configuration
- SRAM_ARB_ROUND_ROBIN_EN:
  - Defined: on simultaneous requests, the requester that did not win last is granted. A 1-bit last-winner register resets to cam, so the cart wins the first tie.
  - Undefined: fixed cart priority, and the last-winner register is not built.

## Structure
- Package gbd_sram_pkg holds:
  - the state enum (IDLE/SETUP/PULSE/HOLD);
  - the owner encoding constants OWN_NONE/OWN_CART/OWN_CAM;
  - the default timing localparams.
- One sub-module, sram_phase_timer: a 4-bit load/decrement counter with a `done` output, instantiated once.

## Test plan
- Write with no contention: cam_req with addr 0x00123, data 0xA5 → sram_nwe low for exactly 6 cycles, addr and data stable from SETUP through HOLD, cam_ack in cycle k+10.
- Cart read: SRAM model returns 0x3C → cart_rdata=0x3C on the cart_ack cycle, sram_noe low for 6 cycles, sram_dq_oe=0 throughout.
- Simultaneous cart_req and cam_req in IDLE:
  - Default build: cart served first, cam_ack 11 cycles after cart_ack.
  - With SRAM_ARB_ROUND_ROBIN_EN, two ties in a row: cart is granted on the first tie, cam on the second.
- Cart request during a cam PULSE → the cam cycle completes unchanged and the cart SETUP begins one IDLE cycle after cam_ack.
- Requester drops req after 1 cycle with its address changed → the cycle completes at the latched address and ack still pulses.
- sys_resetn asserted during PULSE → nwe, ncs and dq_oe return to reset values immediately, no ack; after release, a new request completes in 10 cycles.
